// File: rtl/tsd_pkg.sv
// Shared constants for the test-status device: register word indices, STATUS bit
// positions and the controller state encoding.
package tsd_pkg;

    // Word index of each register (byte offset >> 2)
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_TESTNUM = 2'd1;
    localparam logic [1:0] REG_CYCLES  = 2'd2;
    localparam logic [1:0] REG_TOHOST  = 2'd3;

    localparam int STATUS_DONE    = 0;
    localparam int STATUS_PASS    = 1;
    localparam int STATUS_TIMEOUT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } tsd_state_e;

endpackage

// File: rtl/tsd_if.sv
// Core data-bus port of the test-status device: request/write side from the core,
// grant and one-cycle-late read response back.
interface tsd_bus_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/tsd_cycle_cnt.sv
// Saturating, enable-gated cycle counter. With TSD_TIMEOUT_EN defined it also flags
// the cycle in which the count sits one below the TIMEOUT budget.
module tsd_cycle_cnt #(
    parameter int CNT_W   = 64
`ifdef TSD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
`ifdef TSD_TIMEOUT_EN
    ,
    output logic             tc_o
`endif
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

`ifdef TSD_TIMEOUT_EN
    // Terminal count one early so the state change lands on the TIMEOUT-th edge
    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

endmodule

// File: rtl/test_status_dev.sv
// Test-status device: latches the tohost verdict written by the core and exports
// done/pass/failing test number. Optional run-time budget via TSD_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, no bus access seen yet
// RUN     | test running, cycle counter advancing
// PASS    | tohost == 1 written, absorbing until reset
// FAIL    | odd tohost != 1 written, fail_num latched, absorbing
// TIMEOUT | cycle budget exhausted (TSD_TIMEOUT_EN only), absorbing
module test_status_dev
    import tsd_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 4
`ifdef TSD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1000000
`endif
) (
    input  logic            clk,
    input  logic            rst,
    tsd_bus_if.slave        bus,
    output logic            test_done_o,
    output logic            test_pass_o,
    output logic [XLEN-2:0] fail_num_o
);

    tsd_state_e      state_q;
    tsd_state_e      state_d;
    logic [XLEN-2:0] fail_num_q;
    logic [XLEN-2:0] fail_num_d;
    logic [XLEN-1:0] tohost_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;
    logic            rvalid_q;
    logic [XLEN-1:0] cycles;
    logic [1:0]      reg_sel;
    logic            rd_acc;
    logic            tohost_wr;
    logic            timeout_flag;
    logic            unused_addr;

    // Word decode only; byte lanes within a word alias to the same register
    assign reg_sel     = bus.addr[3:2];
    assign unused_addr = ^bus.addr[1:0];

    assign bus.gnt   = bus.req;
    assign rd_acc    = bus.req && !bus.we;
    assign tohost_wr = bus.req && bus.we && (reg_sel == REG_TOHOST);

`ifdef TSD_TIMEOUT_EN
    logic tc;

    tsd_cycle_cnt #(
        .CNT_W   (XLEN),
        .TIMEOUT (TIMEOUT)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_RUN),
        .cnt_o (cycles),
        .tc_o  (tc)
    );

    assign timeout_flag = (state_q == ST_TIMEOUT);
`else
    tsd_cycle_cnt #(
        .CNT_W (XLEN)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_RUN),
        .cnt_o (cycles)
    );

    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fail_num_d = fail_num_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                // Only odd values are verdicts; a tohost write beats the timeout
                if (tohost_wr && bus.wdata[0]) begin
                    if (bus.wdata == XLEN'(1)) begin
                        state_d    = ST_PASS;
                        fail_num_d = '0;
                    end else begin
                        state_d    = ST_FAIL;
                        fail_num_d = bus.wdata[XLEN-1:1];
                    end
                end
`ifdef TSD_TIMEOUT_EN
                else if ((state_q == ST_RUN) && tc) begin
                    state_d    = ST_TIMEOUT;
                    fail_num_d = '1;
                end
`endif
                else if (bus.req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (rd_acc) begin
            case (reg_sel)
                REG_STATUS: begin
                    rdata_d[STATUS_DONE]    = test_done_o;
                    rdata_d[STATUS_PASS]    = test_pass_o;
                    rdata_d[STATUS_TIMEOUT] = timeout_flag;
                end
                REG_TESTNUM: rdata_d = {1'b0, fail_num_q};
                REG_CYCLES:  rdata_d = cycles;
                REG_TOHOST:  rdata_d = tohost_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fail_num_q <= '0;
            tohost_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            fail_num_q <= fail_num_d;
            rvalid_q   <= rd_acc;
            rdata_q    <= rdata_d;
            if (tohost_wr) begin
                tohost_q <= bus.wdata;
            end
        end
    end

    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign test_done_o = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    assign test_pass_o = (state_q == ST_PASS);
    assign fail_num_o  = fail_num_q;

endmodule
